adc_pipe: RTL
=============

ADC_PIPE -- requirements
Module: adc_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, the operand and result width in bits.
REQ-002 The block SHALL have parameter SEG, default 8, the bits added per pipeline stage; WIDTH SHALL be an integer multiple of SEG, and STAGES = WIDTH/SEG.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port flush, input, 1 bit: synchronous clear of all in-flight operations.
REQ-006 The block SHALL have port in_valid, input, 1 bit: the operand set is valid.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts operands this cycle.
REQ-008 The block SHALL have ports A and B, input, WIDTH bits each: the operands.
REQ-009 The block SHALL have port sub, input, 1 bit: 0 selects A+B, 1 selects A-B.
REQ-010 The block SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-012 The block SHALL have port S, output, WIDTH bits: the result.
REQ-013 The block SHALL have port Co, output, 1 bit: carry out of the MSB (for sub, 1 = no borrow).
REQ-014 The block SHALL have port V, output, 1 bit: two's-complement signed overflow.
REQ-015 The block SHALL have port Z, output, 1 bit: S == 0.

Function
REQ-016 Arithmetic SHALL be S = A + Bx + sub, with Bx = sub ? ~B : B; the sum is WIDTH+1 bits wide and Co is its MSB.
REQ-017 V SHALL be 1 iff A[WIDTH-1] == Bx[WIDTH-1] and S[WIDTH-1] != A[WIDTH-1].
REQ-018 Stage k (0..STAGES-1) SHALL add operand bits [k*SEG +: SEG] plus the carry registered by stage k-1 (stage 0 uses sub), and SHALL register its sum slice, its carry, and the unconsumed upper operand bits.
REQ-019 The pipeline SHALL carry one valid bit per stage; out_valid SHALL be the last stage's valid bit, and S/Co/V/Z SHALL be registered outputs.
REQ-020 Global advance SHALL be adv = !out_valid || out_ready, with in_ready = adv; a transfer occurs on in_valid && in_ready.
REQ-021 When adv = 0, every stage register SHALL hold its value and S/Co/V/Z SHALL remain stable while out_valid = 1.
REQ-022 Latency from input transfer to out_valid SHALL be exactly STAGES cycles with no stall; throughput SHALL be one result per cycle when out_ready is held at 1.
REQ-023 Results SHALL emerge in acceptance order; no operation SHALL be dropped or duplicated.
REQ-024 A cycle with in_valid = 0 and adv = 1 SHALL insert a bubble (valid bit 0) in stage 0.
REQ-025 flush = 1 SHALL clear all valid bits at the next edge regardless of adv; data registers need not be cleared; in_valid is ignored that cycle.
REQ-026 Operands SHALL be treated as unsigned for Co and as two's complement for V; both flags SHALL be valid for every operation.
REQ-027 STAGES = 1 SHALL be legal and SHALL yield 1-cycle latency.

Reset
REQ-028 While rst_n = 0, all valid bits, S, Co, V and Z SHALL be 0, and in_ready SHALL be 1.
REQ-029 Assertion of rst_n mid-operation SHALL discard all in-flight operations immediately; no stale result SHALL appear after release.
REQ-030 The first input transfer SHALL be possible on the first rising edge after rst_n deasserts.

Verification (WIDTH=32, SEG=8, latency 4)
REQ-031 Add A=FFFFFFFF, B=00000001, sub=0, out_ready=1 -> 4 cycles later S=00000000, Co=1, V=0, Z=1.
REQ-032 Sub A=00000000, B=00000001 -> S=FFFFFFFF, Co=0 (borrow), V=0, Z=0; sub A=80000000, B=00000001 -> S=7FFFFFFF, Co=1, V=1.
REQ-033 Add A=7FFFFFFF, B=00000001 -> S=80000000, V=1, Co=0; then stream 8 back-to-back random ops -> 8 consecutive out_valid cycles, in order, all matching the reference model.
REQ-034 Hold out_ready=0 with 4 ops in flight -> out_valid=1, in_ready=0, S stable; release -> remaining results drain one per cycle, none lost.
REQ-035 Flush with 3 ops in flight -> no out_valid for them; the next op accepted afterwards returns correctly after 4 cycles.
REQ-036 Assert rst_n=0 for 1 cycle with 2 ops in flight -> all outputs 0 immediately; no result emerges after release.

Source files
------------

// File: rtl/adc_pipe.sv
// adc_pipe: segmented, pipelined WIDTH-bit adder/subtractor.
// Each stage adds one SEG-bit slice of the operands and passes its carry on
// to the next stage, so the critical path is a SEG-bit adder, not WIDTH bits.
//
// Handshake: a value moves across an interface on a rising edge where its
// valid and ready are both 1. While a valid is 1 and its ready is 0, the
// source holds the value stable. The whole pipeline moves together
// (adv = !out_valid || out_ready), and in_ready is adv, so in_ready never
// depends on in_valid.
module adc_pipe #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Co,
  output logic             V,
  output logic             Z
);

  localparam int STAGES = WIDTH / SEG;
  localparam int L      = STAGES - 1;

  // Per-stage registers. Operands travel along with the partial sum, and the
  // last stage reads their sign bits to compute overflow.
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic [STAGES-1:0] c_q;
  logic [STAGES-1:0] vld_q;
  logic              v_q;
  logic              z_q;

  // Stage inputs and next-state values.
  logic [WIDTH-1:0]  a_in  [STAGES];
  logic [WIDTH-1:0]  b_in  [STAGES];
  logic [WIDTH-1:0]  s_in  [STAGES];
  logic [WIDTH-1:0]  s_nxt [STAGES];
  logic [SEG:0]      part  [STAGES];
  logic [STAGES-1:0] c_in;
  logic [STAGES-1:0] c_nxt;
  logic [STAGES-1:0] vld_nxt;
  logic              v_nxt;
  logic              z_nxt;
  logic              adv;
  logic [WIDTH-1:0]  bx;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign bx       = sub ? ~B : B;

  // Wire each stage to its predecessor and add this stage's slice.
  always_comb begin
    a_in[0]    = A;
    b_in[0]    = bx;
    s_in[0]    = '0;
    c_in[0]    = sub;
    vld_nxt[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      a_in[k]    = a_q[k-1];
      b_in[k]    = b_q[k-1];
      s_in[k]    = s_q[k-1];
      c_in[k]    = c_q[k-1];
      vld_nxt[k] = vld_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      part[k]  = {1'b0, a_in[k][k*SEG +: SEG]} + {1'b0, b_in[k][k*SEG +: SEG]}
               + {{SEG{1'b0}}, c_in[k]};
      s_nxt[k] = s_in[k];
      s_nxt[k][k*SEG +: SEG] = part[k][SEG-1:0];
      c_nxt[k] = part[k][SEG];
    end
    // The last stage sees the complete sum, so the flags are computed there.
    v_nxt = (a_in[L][WIDTH-1] == b_in[L][WIDTH-1]) &&
            (s_nxt[L][WIDTH-1] != a_in[L][WIDTH-1]);
    z_nxt = (s_nxt[L] == '0);
  end

  // Pipeline registers: flush clears only the valid bits; a stall holds everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      c_q   <= '0;
      v_q   <= 1'b0;
      z_q   <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else begin
      if (flush) begin
        vld_q <= '0;
      end else if (adv) begin
        vld_q <= vld_nxt;
      end
      if (adv) begin
        c_q <= c_nxt;
        v_q <= v_nxt;
        z_q <= z_nxt;
        for (int k = 0; k < STAGES; k++) begin
          a_q[k] <= a_in[k];
          b_q[k] <= b_in[k];
          s_q[k] <= s_nxt[k];
        end
      end
    end
  end

  assign out_valid = vld_q[L];
  assign S         = s_q[L];
  assign Co        = c_q[L];
  assign V         = v_q;
  assign Z         = z_q;

endmodule
